// File: rtl/rv_ctrl_pkg.sv
// Shared RV32I control definitions: opcodes, field encodings and the packed
// control word carried in the ID/EX slot of the decode stage.
package rv_ctrl_pkg;

  localparam int CW_ALU_OP_W     = 3;
  localparam int CW_IMM_SRC_W    = 3;
  localparam int CW_RESULT_SRC_W = 2;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [CW_ALU_OP_W-1:0] ALU_ADD   = 3'b000;
  localparam logic [CW_ALU_OP_W-1:0] ALU_SUB   = 3'b001;
  localparam logic [CW_ALU_OP_W-1:0] ALU_CMP   = 3'b100;
  localparam logic [CW_ALU_OP_W-1:0] ALU_FUNCT = 3'b111;

  localparam logic [CW_IMM_SRC_W-1:0] IMM_I = 3'b000;
  localparam logic [CW_IMM_SRC_W-1:0] IMM_S = 3'b001;
  localparam logic [CW_IMM_SRC_W-1:0] IMM_B = 3'b010;
  localparam logic [CW_IMM_SRC_W-1:0] IMM_J = 3'b011;
  localparam logic [CW_IMM_SRC_W-1:0] IMM_U = 3'b100;

  localparam logic [CW_RESULT_SRC_W-1:0] RES_ALU = 2'b00;
  localparam logic [CW_RESULT_SRC_W-1:0] RES_MEM = 2'b01;
  localparam logic [CW_RESULT_SRC_W-1:0] RES_PC4 = 2'b10;
  localparam logic [CW_RESULT_SRC_W-1:0] RES_IMM = 2'b11;

  typedef struct packed {
    logic                       reg_write;
    logic [CW_IMM_SRC_W-1:0]    imm_src;
    logic                       alu_src;
    logic                       mem_write;
    logic [CW_RESULT_SRC_W-1:0] result_src;
    logic                       branch;
    logic [2:0]                 branch_type;
    logic                       jump;
    logic                       jalr;
    logic [CW_ALU_OP_W-1:0]     alu_op;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_NOP = '0;

  // Strips every architectural side effect so a bad word can travel as a trap marker.
  function automatic ctrl_word_t kill_side_effects(input ctrl_word_t cw);
    ctrl_word_t r;
    r           = cw;
    r.reg_write = 1'b0;
    r.mem_write = 1'b0;
    r.branch    = 1'b0;
    r.jump      = 1'b0;
    r.jalr      = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/rv_ctrl_decode.sv
// Purely combinational RV32I main decoder: opcode/funct3 to control word,
// plus an illegal-instruction flag for anything outside the supported subset.
module rv_ctrl_decode
  import rv_ctrl_pkg::*;
#(
  parameter bit EN_JALR = 1'b1
) (
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  output ctrl_word_t  ctrl,
  output logic        illegal
);

  ctrl_word_t raw;

  always_comb begin
    raw     = CTRL_NOP;
    illegal = 1'b0;
    case (opcode)
      OP_LOAD: begin
        raw.reg_write  = 1'b1;
        raw.imm_src    = IMM_I;
        raw.alu_src    = 1'b1;
        raw.result_src = RES_MEM;
        raw.alu_op     = ALU_ADD;
        illegal        = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end
      OP_STORE: begin
        raw.imm_src    = IMM_S;
        raw.alu_src    = 1'b1;
        raw.mem_write  = 1'b1;
        raw.alu_op     = ALU_ADD;
        illegal        = !(funct3 inside {3'b000, 3'b001, 3'b010});
      end
      OP_R: begin
        raw.reg_write  = 1'b1;
        raw.alu_op     = ALU_FUNCT;
      end
      OP_I: begin
        raw.reg_write  = 1'b1;
        raw.imm_src    = IMM_I;
        raw.alu_src    = 1'b1;
        raw.alu_op     = ALU_FUNCT;
      end
      OP_BRANCH: begin
        raw.imm_src     = IMM_B;
        raw.branch      = 1'b1;
        raw.branch_type = funct3;
        // beq compares by subtraction; every other branch uses the comparator class
        raw.alu_op      = (funct3 == 3'b000) ? ALU_SUB : ALU_CMP;
        illegal         = (funct3 inside {3'b010, 3'b011});
      end
      OP_JAL: begin
        raw.reg_write  = 1'b1;
        raw.imm_src    = IMM_J;
        raw.result_src = RES_PC4;
        raw.jump       = 1'b1;
      end
      OP_JALR: begin
        if (EN_JALR) begin
          raw.reg_write  = 1'b1;
          raw.imm_src    = IMM_I;
          raw.alu_src    = 1'b1;
          raw.result_src = RES_PC4;
          raw.jalr       = 1'b1;
          raw.alu_op     = ALU_ADD;
          illegal        = (funct3 != 3'b000);
        end else begin
          illegal        = 1'b1;
        end
      end
      OP_LUI: begin
        raw.reg_write  = 1'b1;
        raw.imm_src    = IMM_U;
        raw.result_src = RES_IMM;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  assign ctrl = illegal ? kill_side_effects(raw) : raw;

endmodule

// File: rtl/rv_decode_stage.sv
// Pipelined decode stage: decodes the incoming instruction and holds the control
// word in a single ID/EX slot with valid/ready flow control, flush and a trap counter.
module rv_decode_stage
  import rv_ctrl_pkg::*;
#(
  parameter int ALU_OP_W  = 3,
  parameter int IMM_SRC_W = 3,
  parameter int ILL_CNT_W = 8,
  parameter bit EN_JALR   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 reg_write,
  output logic [IMM_SRC_W-1:0] imm_src,
  output logic                 alu_src,
  output logic                 mem_write,
  output logic [1:0]           result_src,
  output logic                 branch,
  output logic [2:0]           branch_type,
  output logic                 jump,
  output logic                 jalr,
  output logic [ALU_OP_W-1:0]  alu_op,
  output logic                 illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);

  ctrl_word_t           dec_ctrl;
  logic                 dec_illegal;
  ctrl_word_t           ctrl_q;
  logic                 illegal_q;
  logic                 valid_q;
  logic [ILL_CNT_W-1:0] ill_count_q;
  logic                 accept;
  logic                 take;
  logic                 unused_instr_bits;

  rv_ctrl_decode #(
    .EN_JALR (EN_JALR)
  ) u_decode (
    .opcode  (in_instr[6:0]),
    .funct3  (in_instr[14:12]),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  // Register and immediate fields are consumed by later stages, not by decode.
  assign unused_instr_bits = ^{in_instr[31:15], in_instr[11:7]};

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  // A flush on the accepting edge discards the new word entirely.
  assign take     = accept && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      ctrl_q      <= CTRL_NOP;
      illegal_q   <= 1'b0;
      ill_count_q <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q <= 1'b1;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end

      if (take) begin
        ctrl_q    <= dec_ctrl;
        illegal_q <= dec_illegal;
      end

      if (take && dec_illegal && (ill_count_q != '1)) begin
        ill_count_q <= ill_count_q + ILL_CNT_W'(1);
      end
    end
  end

  assign out_valid   = valid_q;
  assign reg_write   = ctrl_q.reg_write;
  assign imm_src     = IMM_SRC_W'(ctrl_q.imm_src);
  assign alu_src     = ctrl_q.alu_src;
  assign mem_write   = ctrl_q.mem_write;
  assign result_src  = ctrl_q.result_src;
  assign branch      = ctrl_q.branch;
  assign branch_type = ctrl_q.branch_type;
  assign jump        = ctrl_q.jump;
  assign jalr        = ctrl_q.jalr;
  assign alu_op      = ALU_OP_W'(ctrl_q.alu_op);
  assign illegal     = illegal_q;
  assign ill_count   = ill_count_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Self-checking bench for rv_decode_stage: directed vector table, handshake corner
// sequences, counter saturation on a narrow instance, and randomized traffic vs. a model.
module tb_rv_decode_stage;

  typedef struct packed {
    logic       reg_write;
    logic [2:0] imm_src;
    logic       alu_src;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic [2:0] branch_type;
    logic       jump;
    logic       jalr;
    logic [2:0] alu_op;
    logic       illegal;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    exp_t        exp;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        reg_write;
  logic [2:0]  imm_src;
  logic        alu_src;
  logic        mem_write;
  logic [1:0]  result_src;
  logic        branch;
  logic [2:0]  branch_type;
  logic        jump;
  logic        jalr;
  logic [2:0]  alu_op;
  logic        illegal;
  logic [7:0]  ill_count;

  logic        s_rst;
  logic        s_in_valid;
  logic        s_in_ready;
  logic [31:0] s_in_instr;
  logic        s_flush;
  logic        s_out_valid;
  logic        s_out_ready;
  logic        s_reg_write;
  logic [2:0]  unused_s_imm_src;
  logic        unused_s_alu_src;
  logic        unused_s_mem_write;
  logic [1:0]  unused_s_result_src;
  logic        unused_s_branch;
  logic [2:0]  unused_s_branch_type;
  logic        unused_s_jump;
  logic        s_jalr;
  logic [2:0]  unused_s_alu_op;
  logic        s_illegal;
  logic [1:0]  s_ill_count;

  int n_compared;
  int n_mismatched;
  int exp_cnt;

  rv_decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .reg_write(reg_write), .imm_src(imm_src), .alu_src(alu_src), .mem_write(mem_write),
    .result_src(result_src), .branch(branch), .branch_type(branch_type), .jump(jump),
    .jalr(jalr), .alu_op(alu_op), .illegal(illegal), .ill_count(ill_count)
  );

  // Narrow counter and JALR disabled, to reach saturation and the JALR-off decode quickly.
  rv_decode_stage #(.ILL_CNT_W(2), .EN_JALR(1'b0)) dut_narrow (
    .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_instr(s_in_instr), .flush(s_flush), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .reg_write(s_reg_write), .imm_src(unused_s_imm_src), .alu_src(unused_s_alu_src),
    .mem_write(unused_s_mem_write), .result_src(unused_s_result_src),
    .branch(unused_s_branch), .branch_type(unused_s_branch_type), .jump(unused_s_jump),
    .jalr(s_jalr), .alu_op(unused_s_alu_op), .illegal(s_illegal), .ill_count(s_ill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic rw, input logic [2:0] imm, input logic asrc,
                              input logic mw, input logic [1:0] res, input logic br,
                              input logic [2:0] bt, input logic j, input logic jr,
                              input logic [2:0] alu, input logic ill);
    return {rw, imm, asrc, mw, res, br, bt, j, jr, alu, ill};
  endfunction

  // Reference decode straight from the instruction-set rules.
  function automatic exp_t ref_decode(input logic [6:0] opc, input logic [2:0] f3,
                                      input bit en_jalr);
    exp_t e;
    e = '0;
    if (opc == 7'b0000011) begin
      e.reg_write = 1; e.alu_src = 1; e.result_src = 2'b01;
      e.illegal = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    end else if (opc == 7'b0100011) begin
      e.imm_src = 3'd1; e.alu_src = 1; e.mem_write = 1;
      e.illegal = (f3 > 3'd2);
    end else if (opc == 7'b0110011) begin
      e.reg_write = 1; e.alu_op = 3'b111;
    end else if (opc == 7'b0010011) begin
      e.reg_write = 1; e.alu_src = 1; e.alu_op = 3'b111;
    end else if (opc == 7'b1100011) begin
      e.imm_src = 3'd2; e.branch = 1; e.branch_type = f3;
      e.alu_op = (f3 == 3'd0) ? 3'b001 : 3'b100;
      e.illegal = (f3 == 3'd2) || (f3 == 3'd3);
    end else if (opc == 7'b1101111) begin
      e.reg_write = 1; e.imm_src = 3'd3; e.result_src = 2'b10; e.jump = 1;
    end else if (opc == 7'b1100111 && en_jalr) begin
      e.reg_write = 1; e.alu_src = 1; e.result_src = 2'b10; e.jalr = 1;
      e.illegal = (f3 != 3'd0);
    end else if (opc == 7'b0110111) begin
      e.reg_write = 1; e.imm_src = 3'd4; e.result_src = 2'b11;
    end else begin
      e.illegal = 1;
    end
    if (e.illegal) begin
      e.reg_write = 0; e.mem_write = 0; e.branch = 0; e.jump = 0; e.jalr = 0;
    end
    return e;
  endfunction

  function automatic exp_t cur_word();
    return {reg_write, imm_src, alu_src, mem_write, result_src, branch, branch_type,
            jump, jalr, alu_op, illegal};
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [6:0]  ops [9];
    logic [31:0] r;
    int          k;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b1110011};
    r = $urandom();
    k = $urandom_range(0, 10);
    if (k < 9) r[6:0] = ops[k];
    return r;
  endfunction

  task automatic checkOutput(input string what, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, want %h", what, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] instr);
    in_instr = instr;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  vec_t       vecs [14];
  exp_t       m_word;
  logic       m_valid;
  int         m_cnt;
  logic       acc;
  logic [1:0] sat_exp [5];
  logic [31:0] sat_words [5];

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    exp_cnt      = 0;

    vecs[0]  = '{32'h00012083, mk(1, 3'd0, 1, 0, 2'b01, 0, 3'd0, 0, 0, 3'b000, 0)};
    vecs[1]  = '{32'h00112023, mk(0, 3'd1, 1, 1, 2'b00, 0, 3'd0, 0, 0, 3'b000, 0)};
    vecs[2]  = '{32'h008000EF, mk(1, 3'd3, 0, 0, 2'b10, 0, 3'd0, 1, 0, 3'b000, 0)};
    vecs[3]  = '{32'h00209463, mk(0, 3'd2, 0, 0, 2'b00, 1, 3'd1, 0, 0, 3'b100, 0)};
    vecs[4]  = '{32'h0020A463, mk(0, 3'd2, 0, 0, 2'b00, 0, 3'd2, 0, 0, 3'b100, 1)};
    vecs[5]  = '{32'h002081B3, mk(1, 3'd0, 0, 0, 2'b00, 0, 3'd0, 0, 0, 3'b111, 0)};
    vecs[6]  = '{32'h00108093, mk(1, 3'd0, 1, 0, 2'b00, 0, 3'd0, 0, 0, 3'b111, 0)};
    vecs[7]  = '{32'h00208063, mk(0, 3'd2, 0, 0, 2'b00, 1, 3'd0, 0, 0, 3'b001, 0)};
    vecs[8]  = '{32'h000080E7, mk(1, 3'd0, 1, 0, 2'b10, 0, 3'd0, 0, 1, 3'b000, 0)};
    vecs[9]  = '{32'h000090E7, mk(0, 3'd0, 1, 0, 2'b10, 0, 3'd0, 0, 0, 3'b000, 1)};
    vecs[10] = '{32'h123450B7, mk(1, 3'd4, 0, 0, 2'b11, 0, 3'd0, 0, 0, 3'b000, 0)};
    vecs[11] = '{32'h0000B083, mk(0, 3'd0, 1, 0, 2'b01, 0, 3'd0, 0, 0, 3'b000, 1)};
    vecs[12] = '{32'h0000B023, mk(0, 3'd1, 1, 0, 2'b00, 0, 3'd0, 0, 0, 3'b000, 1)};
    vecs[13] = '{32'hFFFFFFFF, mk(0, 3'd0, 0, 0, 2'b00, 0, 3'd0, 0, 0, 3'b000, 1)};

    rst = 1'b1; in_valid = 1'b1; in_instr = 32'hFFFFFFFF; flush = 1'b0; out_ready = 1'b1;
    s_rst = 1'b1; s_in_valid = 1'b0; s_in_instr = 32'h0; s_flush = 1'b0; s_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset ill_count", {24'd0, ill_count}, 32'd0);
    checkOutput("reset word", {14'd0, cur_word()}, 32'd0);
    rst = 1'b0; s_rst = 1'b0; in_valid = 1'b0;
    #1;
    checkOutput("in_ready after reset", {31'd0, in_ready}, 32'd1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].instr);
      if (vecs[i].exp.illegal) exp_cnt++;
      checkOutput($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, 32'd1);
      checkOutput($sformatf("vec%0d word", i), {14'd0, cur_word()}, {14'd0, vecs[i].exp});
      checkOutput($sformatf("vec%0d ill_count", i), {24'd0, ill_count}, exp_cnt);
    end

    // Stall: sw held while jal waits upstream.
    applyStimulus(32'h00112023);
    out_ready = 1'b0; in_instr = 32'h008000EF; in_valid = 1'b1;
    #1;
    checkOutput("stall in_ready", {31'd0, in_ready}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("stall%0d in_ready", c), {31'd0, in_ready}, 32'd0);
      checkOutput($sformatf("stall%0d out_valid", c), {31'd0, out_valid}, 32'd1);
      checkOutput($sformatf("stall%0d mem_write", c), {31'd0, mem_write}, 32'd1);
      checkOutput($sformatf("stall%0d jump", c), {31'd0, jump}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("unstall in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("jal after stall", {14'd0, cur_word()},
                {14'd0, mk(1, 3'd3, 0, 0, 2'b10, 0, 3'd0, 1, 0, 3'b000, 0)});

    // Flush coinciding with accept of an illegal word.
    in_instr = 32'hFFFFFFFF; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("flush out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("flush ill_count", {24'd0, ill_count}, exp_cnt);
    checkOutput("flush keeps word", {31'd0, jump}, 32'd1);

    // Flush of a held word with no new instruction.
    applyStimulus(32'h00012083);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush held out_valid", {31'd0, out_valid}, 32'd0);

    // Saturation on the 2-bit counter, JALR illegal there.
    sat_words = '{32'h00000067, 32'hFFFFFFFF, 32'h0020B463, 32'h0000F003, 32'h0000007F};
    sat_exp   = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int k = 0; k < 5; k++) begin
      s_in_instr = sat_words[k]; s_in_valid = 1'b1;
      @(posedge clk);
      #1;
      s_in_valid = 1'b0;
      checkOutput($sformatf("sat%0d ill_count", k), {30'd0, s_ill_count}, {30'd0, sat_exp[k]});
      checkOutput($sformatf("sat%0d illegal", k), {31'd0, s_illegal}, 32'd1);
      checkOutput($sformatf("sat%0d out_valid", k), {31'd0, s_out_valid}, 32'd1);
      if (k == 0) begin
        checkOutput("jalr-off jalr", {31'd0, s_jalr}, 32'd0);
        checkOutput("jalr-off reg_write", {31'd0, s_reg_write}, 32'd0);
      end
    end
    checkOutput("narrow in_ready", {31'd0, s_in_ready}, 32'd1);

    // Randomized traffic against a single-slot model.
    m_valid = 1'b0; m_cnt = exp_cnt; m_word = '0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_instr  = gen_instr();
      #1;
      checkOutput("rand in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
      @(posedge clk);
      acc = in_valid && (!m_valid || out_ready);
      if (acc && !flush) begin
        m_word = ref_decode(in_instr[6:0], in_instr[14:12], 1'b1);
        if (m_word.illegal && m_cnt < 255) m_cnt++;
      end
      if (flush) m_valid = 1'b0;
      else if (acc) m_valid = 1'b1;
      else if (out_ready) m_valid = 1'b0;
      #1;
      checkOutput("rand out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      if (m_valid) checkOutput("rand word", {14'd0, cur_word()}, {14'd0, m_word});
      checkOutput("rand ill_count", {24'd0, ill_count}, m_cnt);
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Pipelined successor to the single-cycle main decoder.
- Decodes the RV32I base opcodes and registers the control word into an ID/EX pipeline slot.
- Uses a valid/ready handshake with stall and flush.
- Flags illegal instructions and counts them in a saturating counter.
- Sits between the fetch/IF-ID register and the execute stage of the RISCV32 core.

Parameters:
- ALU_OP_W, 3: width of alu_op (codes ADD=000, SUB=001, CMP=100, FUNCT=111; other codes reserved).
- IMM_SRC_W, 3: width of imm_src (I=000, S=001, B=010, J=011, U=100).
- ILL_CNT_W, 8: width of the saturating illegal-instruction counter.
- EN_JALR, 1: 1 decodes JALR (1100111); 0 treats it as illegal.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  instruction on in_instr is valid.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_instr  in  32  full instruction word; opcode=[6:0], funct3=[14:12].
- flush  in  1  kill the held instruction (branch/jump taken).
- out_valid  out  1  control word valid.
- out_ready  in  1  execute stage accepts the control word.
- reg_write  out  1  register file write enable.
- imm_src  out  IMM_SRC_W  immediate format select.
- alu_src  out  1  0 = rs2, 1 = immediate.
- mem_write  out  1  data memory write enable.
- result_src  out  2  00 = ALU, 01 = memory, 10 = PC+4, 11 = immediate (LUI).
- branch  out  1  conditional branch.
- branch_type  out  3  funct3 of the branch.
- jump  out  1  JAL.
- jalr  out  1  JALR (target = rs1+imm).
- alu_op  out  ALU_OP_W  ALU operation class.
- illegal  out  1  held instruction is illegal.
- ill_count  out  ILL_CNT_W  saturating count of accepted illegal instructions.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): out_valid=0, ill_count=0.
  - All control outputs 0, except imm_src=000 and result_src=00.
  - rst has priority over flush and the handshake.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; no combinational path from in_instr).
  - Accept when in_valid && in_ready. The decoded word is registered; latency is 1 cycle to out_valid.
  - out_valid && !out_ready holds all outputs stable (stall).
- Flush: on a flush edge, out_valid <= 0 and any simultaneous accept is discarded; ill_count is not incremented for a discarded instruction.
- Decode table (all unlisted fields 0):
  - LOAD 0000011: reg_write=1, imm_src=I, alu_src=1, result_src=01, alu_op=ADD.
  - STORE 0100011: imm_src=S, alu_src=1, mem_write=1, alu_op=ADD.
  - R 0110011: reg_write=1, alu_op=FUNCT.
  - I 0010011: reg_write=1, imm_src=I, alu_src=1, alu_op=FUNCT.
  - BRANCH 1100011: imm_src=B, branch=1, branch_type=funct3; alu_op=CMP for funct3 in {001,100,101,110,111}, SUB for 000.
  - JAL 1101111: reg_write=1, imm_src=J, result_src=10, jump=1.
  - JALR 1100111 (EN_JALR=1, funct3=000): reg_write=1, imm_src=I, alu_src=1, result_src=10, jalr=1, alu_op=ADD.
  - LUI 0110111: reg_write=1, imm_src=U, result_src=11.
- Illegal conditions:
  - opcode not in the table;
  - BRANCH with funct3 in {010,011};
  - LOAD funct3 not in {000,001,010,100,101};
  - STORE funct3 not in {000,001,010};
  - JALR with funct3≠000.
- Illegal response: illegal=1; reg_write, mem_write, branch, jump and jalr forced to 0; out_valid still asserted (it passes down the pipe as a trap marker).
- ill_count: increments by 1 on each accepted illegal instruction that is not flushed; saturates at all-ones with no wrap.
- The held word changes only on accept; a flush or stall never produces a partial update.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - opcode localparams;
  - ALU_OP, IMM_SRC and RESULT_SRC encodings;
  - the packed control-word struct type.
- One combinational sub-module, rv_ctrl_decode: instr to control word plus illegal.
- The top block holds the pipeline register, handshake, flush logic and counter.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, ill_count=0, all enables 0; in_ready=1 after release.
- Load: in_instr=0x00012083 (lw), out_ready=1 -> next cycle out_valid=1, reg_write=1, result_src=01, alu_src=1, imm_src=000, alu_op=000.
- Stall: accept 0x00112023 (sw), drop out_ready for 3 cycles while presenting 0x008000EF (jal) -> in_ready=0; mem_write=1 held; jal appears (jump=1, result_src=10, imm_src=011) one cycle after out_ready returns.
- Branch and illegal: 0x00209463 (bne) -> branch=1, branch_type=001, alu_op=100; 0x0020A463 (funct3=010) -> illegal=1, branch=0, ill_count=1.
- Flush: a flush edge coinciding with the accept of an illegal 0xFFFFFFFF -> out_valid=0 next cycle, ill_count unchanged.
- Saturation: ILL_CNT_W=2, feed 5 accepted illegal words -> ill_count sequence 1,2,3,3,3.
